// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: decoded opcodes, FSM state
// encoding and fault codes reported on faultCode.
package seq_pkg;

  localparam logic [3:0] OP_JUMP  = 4'h2;
  localparam logic [3:0] OP_CJUMP = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hE;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt,
    StFault
  } seq_state_e;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_NO_PROG = 2'b01;
  localparam logic [1:0] FAULT_RANGE   = 2'b10;
  localparam logic [1:0] FAULT_STEPS   = 2'b11;

endpackage

// File: rtl/program_select_encoder.sv
// Lowest-set-bit priority encoder for the program select switches.
//   sel_raw    in  8  raw switch vector
//   sel_onehot out 8  one-hot vector keeping only the lowest set bit (0 if none)
module program_select_encoder (
  input  logic [7:0] sel_raw,
  output logic [7:0] sel_onehot
);

  // Two's-complement trick: x & -x isolates the lowest set bit.
  assign sel_onehot = sel_raw & (~sel_raw + 8'd1);

endmodule

// File: rtl/program_sequencer.sv
// Fetch/sequence controller. Owns the PC, fetches 16-bit instructions, resolves
// JUMP / CJUMP / HALT internally and issues everything else to the execute
// datapath over a valid/ready handshake. Enforces PC range and step limits.
//   clk, resetN            clock, async active-low reset
//   start, abort           run control (abort wins)
//   programSelect          raw select switches, latched on start
//   memProgramSelect/memAddress/memInstruction   instruction memory port
//   issueValid/issueInstr/issueReady             execute datapath handshake
//   condReg/condNonZero    condition register query for CJUMP
//   busy/halted/fault/faultCode/stepCount        status
module program_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 128,
  parameter int unsigned MAX_STEPS  = 1024
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  programSelect,
  output logic [7:0]  memProgramSelect,
  output logic [7:0]  memAddress,
  input  logic [15:0] memInstruction,
  output logic        issueValid,
  output logic [15:0] issueInstr,
  input  logic        issueReady,
  output logic [3:0]  condReg,
  input  logic        condNonZero,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  faultCode,
  output logic [15:0] stepCount
);

  localparam logic signed [9:0] DepthS    = 10'(PROG_DEPTH);
  localparam logic [15:0]       MaxStepsW = 16'(MAX_STEPS);

  seq_state_e  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] step_q, step_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [7:0]  sel_q, sel_d;
  logic [7:0]  sel_enc;

  program_select_encoder u_sel_enc (
    .sel_raw    (programSelect),
    .sel_onehot (sel_enc)
  );

  // Instruction decode
  logic [3:0] opcode;
  logic       is_halt, is_jump, is_cjump, is_issue;

  assign opcode   = instr_q[15:12];
  assign is_halt  = (opcode == OP_HALT);
  assign is_jump  = (opcode == OP_JUMP) && (instr_q[11:8] == 4'h0);
  assign is_cjump = (opcode == OP_CJUMP);
  assign is_issue = !(is_halt || is_jump || is_cjump);

  // Signed 10-bit target so underflow and overflow past PROG_DEPTH are visible.
  logic signed [9:0] offset, target;
  logic              target_bad;

  always_comb begin
    offset = '0;
    if (is_jump) begin
      offset = {{2{instr_q[7]}}, instr_q[7:0]};
    end else if (is_cjump && condNonZero) begin
      offset = {{6{instr_q[3]}}, instr_q[3:0]};
    end
    target = $signed({2'b00, pc_q}) + 10'sd1 + offset;
  end

  assign target_bad = target[9] || (target >= DepthS);

  logic retire;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    step_d       = step_q;
    fault_code_d = fault_code_q;
    sel_d        = sel_q;
    retire       = 1'b0;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StHalt, StFault: begin
          if (start) begin
            sel_d        = sel_enc;
            pc_d         = '0;
            step_d       = '0;
            fault_code_d = FAULT_NONE;
            if (sel_enc == 8'h00) begin
              state_d      = StFault;
              fault_code_d = FAULT_NO_PROG;
            end else begin
              state_d = StFetch;
            end
          end
        end
        StFetch: begin
          instr_d = memInstruction;
          state_d = StExec;
        end
        StExec: begin
          if (is_halt) begin
            step_d  = step_q + 16'd1;
            state_d = StHalt;
            retire  = 1'b1;
          end else if (!is_issue || issueReady) begin
            if (target_bad) begin
              state_d      = StFault;
              fault_code_d = FAULT_RANGE;
            end else begin
              pc_d    = target[7:0];
              step_d  = step_q + 16'd1;
              state_d = StFetch;
              retire  = 1'b1;
            end
          end
          // Watchdog: the instruction still retires, but the run stops here.
          if (retire && (step_d == MaxStepsW)) begin
            state_d      = StFault;
            fault_code_d = FAULT_STEPS;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      instr_q      <= '0;
      step_q       <= '0;
      fault_code_q <= FAULT_NONE;
      sel_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      step_q       <= step_d;
      fault_code_q <= fault_code_d;
      sel_q        <= sel_d;
    end
  end

  assign memProgramSelect = sel_q;
  assign memAddress       = pc_q;
  assign issueInstr       = instr_q;
  // Abort drops valid in the same cycle, ahead of the state change.
  assign issueValid       = (state_q == StExec) && is_issue && !abort;
  assign condReg          = instr_q[7:4];
  assign busy             = (state_q == StFetch) || (state_q == StExec);
  assign halted           = (state_q == StHalt);
  assign fault            = (state_q == StFault);
  assign faultCode        = fault_code_q;
  assign stepCount        = step_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer; a second instance with MAX_STEPS = 4
// exercises the step-limit watchdog.
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [7:0]  program_select;
  logic [7:0]  mem_program_select, mem_address;
  logic [15:0] mem_instruction;
  logic        issue_valid, issue_ready;
  logic [15:0] issue_instr;
  logic [3:0]  cond_reg;
  logic        cond_nz;
  logic        busy, halted, fault;
  logic [1:0]  fault_code;
  logic [15:0] step_count;

  logic [15:0] mem [256];
  assign mem_instruction = mem[mem_address];

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk              (clk),
    .resetN           (reset_n),
    .start            (start),
    .abort            (abort),
    .programSelect    (program_select),
    .memProgramSelect (mem_program_select),
    .memAddress       (mem_address),
    .memInstruction   (mem_instruction),
    .issueValid       (issue_valid),
    .issueInstr       (issue_instr),
    .issueReady       (issue_ready),
    .condReg          (cond_reg),
    .condNonZero      (cond_nz),
    .busy             (busy),
    .halted           (halted),
    .fault            (fault),
    .faultCode        (fault_code),
    .stepCount        (step_count)
  );

  // Watchdog instance: memory always returns JUMP -1 (tight self-loop).
  logic        wd_start, wd_abort;
  logic [7:0]  wd_sel_in, wd_mem_sel, wd_addr;
  logic        wd_valid, wd_busy, wd_halted, wd_fault;
  logic [15:0] wd_instr, wd_steps;
  logic [3:0]  wd_cond_reg;
  logic [1:0]  wd_code;

  program_sequencer #(
    .MAX_STEPS (4)
  ) dut_wd (
    .clk              (clk),
    .resetN           (reset_n),
    .start            (wd_start),
    .abort            (wd_abort),
    .programSelect    (wd_sel_in),
    .memProgramSelect (wd_mem_sel),
    .memAddress       (wd_addr),
    .memInstruction   (16'h20FF),
    .issueValid       (wd_valid),
    .issueInstr       (wd_instr),
    .issueReady       (1'b1),
    .condReg          (wd_cond_reg),
    .condNonZero      (1'b0),
    .busy             (wd_busy),
    .halted           (wd_halted),
    .fault            (wd_fault),
    .faultCode        (wd_code),
    .stepCount        (wd_steps)
  );

  int n_checked = 0;
  int n_failed  = 0;
  int issue_cnt = 0;

  always @(posedge clk) if (issue_valid && issue_ready) issue_cnt <= issue_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checked++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
  endtask

  // Pulse start for one edge; returns one edge later (FETCH if a program is selected).
  task automatic do_start(input logic [7:0] sel);
    program_select = sel;
    start = 1'b1;
    run(1);
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; program_select = 8'h00;
    issue_ready = 1'b1; cond_nz = 1'b0;
    wd_start = 1'b0; wd_abort = 1'b0; wd_sel_in = 8'h80;
    clear_mem();
    #12;
    check_eq("rst_addr",   {24'h0, mem_address}, 32'h0);
    check_eq("rst_sel",    {24'h0, mem_program_select}, 32'h0);
    check_eq("rst_valid",  {31'h0, issue_valid}, 32'h0);
    check_eq("rst_instr",  {16'h0, issue_instr}, 32'h0);
    check_eq("rst_status", {28'h0, busy, halted, fault, 1'b0}, 32'h0);
    check_eq("rst_code",   {30'h0, fault_code}, 32'h0);
    check_eq("rst_steps",  {16'h0, step_count}, 32'h0);
    reset_n = 1'b1;
    run(1);

    // Basic run: select 0x06 -> bit 1, issue 0x1100, then HALT.
    mem[0] = 16'h1100; mem[1] = 16'hE000;
    issue_cnt = 0;
    do_start(8'h06);
    check_eq("t1_sel",   {24'h0, mem_program_select}, 32'h02);
    check_eq("t1_busy",  {31'h0, busy}, 32'h1);
    run(1);
    check_eq("t1_valid", {31'h0, issue_valid}, 32'h1);
    check_eq("t1_instr", {16'h0, issue_instr}, 32'h1100);
    run(1);
    check_eq("t1_addr1", {24'h0, mem_address}, 32'h01);
    run(1);
    check_eq("t1_nohalt_yet", {30'h0, halted, issue_valid}, 32'h0);
    run(1);
    check_eq("t1_halted", {31'h0, halted}, 32'h1);
    check_eq("t1_steps",  {16'h0, step_count}, 32'd2);
    check_eq("t1_issues", issue_cnt, 32'd1);

    // No program selected.
    issue_cnt = 0;
    do_start(8'h00);
    check_eq("t2_fault", {31'h0, fault}, 32'h1);
    check_eq("t2_code",  {30'h0, fault_code}, 32'h1);
    check_eq("t2_valid", {31'h0, issue_valid}, 32'h0);
    run(1);
    check_eq("t2_issues", issue_cnt, 32'd0);

    // Jumps: 0:J+6 ->7, 7:J+1 ->9, 9:J+2 ->12, 12:CJUMP r5,-3 ->10 or 13.
    clear_mem();
    mem[0] = 16'h2006; mem[7] = 16'h2001; mem[9] = 16'h2002; mem[12] = 16'hC05D;
    cond_nz = 1'b1;
    do_start(8'h01);
    run(2);
    check_eq("t3_pc7", {24'h0, mem_address}, 32'd7);
    run(2);
    check_eq("t3_pc9", {24'h0, mem_address}, 32'd9);
    program_select = 8'h10;
    run(2);
    check_eq("t3_pc12", {24'h0, mem_address}, 32'd12);
    check_eq("t3_sel_held", {24'h0, mem_program_select}, 32'h01);
    run(1);
    check_eq("t3_condreg", {28'h0, cond_reg}, 32'd5);
    run(1);
    check_eq("t3_cj_taken", {24'h0, mem_address}, 32'd10);
    run(2);
    check_eq("t3_halted", {31'h0, halted}, 32'h1);
    check_eq("t3_steps",  {16'h0, step_count}, 32'd5);
    cond_nz = 1'b0;
    do_start(8'h01);
    run(8);
    check_eq("t3_cj_not_taken", {24'h0, mem_address}, 32'd13);
    run(2);

    // Range fault: 0:J+2 ->3, 3:J-16 -> target -12.
    clear_mem();
    mem[0] = 16'h2002; mem[3] = 16'h20F0;
    do_start(8'h01);
    run(4);
    check_eq("t4_fault", {31'h0, fault}, 32'h1);
    check_eq("t4_code",  {30'h0, fault_code}, 32'h2);
    check_eq("t4_pc",    {24'h0, mem_address}, 32'd3);
    check_eq("t4_steps", {16'h0, step_count}, 32'd1);

    // Backpressure and abort.
    clear_mem();
    mem[0] = 16'h3456; mem[1] = 16'h3000;
    issue_ready = 1'b0;
    do_start(8'h01);
    run(1);
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_hold_valid", {31'h0, issue_valid}, 32'h1);
      check_eq("t5_hold_instr", {16'h0, issue_instr}, 32'h3456);
      check_eq("t5_hold_pc",    {24'h0, mem_address}, 32'd0);
      run(1);
    end
    issue_ready = 1'b1;
    run(1);
    check_eq("t5_pc1",    {24'h0, mem_address}, 32'd1);
    check_eq("t5_steps1", {16'h0, step_count}, 32'd1);
    issue_ready = 1'b0;
    run(1);
    check_eq("t5_valid2", {31'h0, issue_valid}, 32'h1);
    run(2);
    abort = 1'b1;
    #1;
    check_eq("t5_abort_drop", {31'h0, issue_valid}, 32'h0);
    run(1);
    abort = 1'b0;
    check_eq("t5_idle",      {31'h0, busy}, 32'h0);
    check_eq("t5_pc_held",   {24'h0, mem_address}, 32'd1);
    check_eq("t5_step_held", {16'h0, step_count}, 32'd1);
    check_eq("t5_sel_held",  {24'h0, mem_program_select}, 32'h01);
    program_select = 8'h01;
    start = 1'b1; abort = 1'b1;
    run(1);
    start = 1'b0; abort = 1'b0;
    check_eq("t5_abort_wins", {29'h0, busy, halted, fault}, 32'h0);

    // Watchdog instance: 4th retirement trips the limit.
    wd_start = 1'b1;
    run(1);
    wd_start = 1'b0;
    run(7);
    check_eq("t6_pre_fault", {31'h0, wd_fault}, 32'h0);
    check_eq("t6_pre_steps", {16'h0, wd_steps}, 32'd3);
    run(1);
    check_eq("t6_fault", {31'h0, wd_fault}, 32'h1);
    check_eq("t6_code",  {30'h0, wd_code}, 32'h3);
    check_eq("t6_steps", {16'h0, wd_steps}, 32'd4);

    // Asynchronous reset mid-handshake.
    clear_mem();
    mem[0] = 16'h3456;
    issue_ready = 1'b0;
    do_start(8'h01);
    run(1);
    check_eq("t7_valid", {31'h0, issue_valid}, 32'h1);
    reset_n = 1'b0;
    #1;
    check_eq("t7_rst_valid", {31'h0, issue_valid}, 32'h0);
    check_eq("t7_rst_instr", {16'h0, issue_instr}, 32'h0);
    #2;
    reset_n = 1'b1;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Fetch/sequence controller for the instruction memory and execute datapath. It latches a one-hot program select, owns the program counter, and fetches 16-bit instructions over an 8-bit address. JUMP, conditional jump and HALT are resolved internally; every other instruction is issued to the execute datapath through a valid/ready handshake. It also enforces program-range and step-count limits, and reports halt and fault status for display and control logic.

## Interface
- PROG_DEPTH, 128: number of valid instruction words per program; legal PCs are 0..PROG_DEPTH-1.
- MAX_STEPS, 1024: retired-instruction limit before a watchdog fault.
- clk  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle pulse; begins a run from PC 0.
- abort  in  1  synchronous abort; returns the block to IDLE.
- programSelect  in  8  raw switch vector.
- memProgramSelect  out  8  latched one-hot select, driven to instruction memory.
- memAddress  out  8  current PC, driven to instruction memory.
- memInstruction  in  16  instruction word; combinational response to memAddress and memProgramSelect.
- issueValid  out  1  issued instruction is valid.
- issueInstr  out  16  registered instruction word.
- issueReady  in  1  datapath accepts the issued instruction.
- condReg  out  4  register index for the condition (instrReg[7:4]).
- condNonZero  in  1  datapath's combinational result: register condReg is non-zero.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.
- faultCode  out  2  01 = no program, 10 = PC out of range, 11 = step limit.
- stepCount  out  16  instructions retired in the current run, including control instructions.

## Operation
- States: IDLE, FETCH, EXEC, HALT, FAULT.
- Program select encoding is lowest-set-bit priority, producing a one-hot result.
- In IDLE, HALT or FAULT, `start`:
  - latches the encoded select into memProgramSelect;
  - clears pc, stepCount and faultCode;
  - goes to FAULT with code 01 if the encoded select is zero, otherwise to FETCH.
- `start` is ignored in FETCH and EXEC.
- FETCH: memAddress = pc. At the clock edge, instrReg <= memInstruction, then go to EXEC.
- EXEC decodes by opcode instrReg[15:12]:
  - 0xE (HALT): stepCount+1, go to HALT, pc unchanged.
  - 0x2 with instrReg[11:8] == 0 (JUMP): target = pc + 1 + sext(instrReg[7:0]).
  - 0xC (CJUMP): if condNonZero, target = pc + 1 + sext(instrReg[3:0]); else target = pc + 1.
  - All others: issueValid = 1 and hold until issueReady. On the handshake cycle, target = pc + 1.
- Target arithmetic is signed, 10 bits, with no wrap-around.
  - If target < 0 or target ≥ PROG_DEPTH: go to FAULT, code 10, pc unchanged.
  - Otherwise: pc <= target[7:0], stepCount+1, go to FETCH.
- Watchdog: if a retirement would make stepCount equal MAX_STEPS, go to FAULT with code 11. The instruction still retires.
- `abort` goes to IDLE from any state and drops issueValid that cycle. memProgramSelect is held; pc and stepCount are held.
- If `abort` and `start` arrive together, `abort` wins.
- A programSelect change mid-run has no effect until the next `start`.

## Timing
- Reset values:
  - state IDLE; pc = 0; memAddress = 0; memProgramSelect = 0;
  - issueValid = 0; issueInstr = 0; busy = halted = fault = 0;
  - faultCode = 00; stepCount = 0.
- `start` → FETCH on the next edge.
- Throughput:
  - ALU/load instruction: 2 cycles minimum (FETCH, EXEC with issueReady already high). Each cycle issueReady stays low adds one cycle.
  - JUMP, CJUMP, HALT: 2 cycles.
- issueValid:
  - asserted only in EXEC for issued opcodes;
  - issueInstr is stable while valid;
  - never deasserted without the handshake, except on `abort`.
- condNonZero is sampled only in the EXEC cycle of a CJUMP.
- halted and fault are registered and asserted on the edge of entering the state.
- An asynchronous reset mid-handshake drops issueValid immediately.

## Structure
- Package `seq_pkg` holds:
  - opcode constants: OP_JUMP = 4'h2, OP_CJUMP = 4'hC, OP_HALT = 4'hE;
  - the state enum;
  - the fault-code constants.
- Sub-module `program_select_encoder`: combinational lowest-bit priority encoder, 8-bit in, 8-bit one-hot out.
- The FSM, pc, instrReg and stepCount live in the top module.

## Test plan
- Select 0x06 (bit 1 wins), start, memory returns 0x1100 then 0xE000, issueReady = 1:
  - memProgramSelect = 0x02;
  - one issue of 0x1100;
  - halted at cycle 4; stepCount = 2.
- Start with programSelect = 0x00 → fault = 1, faultCode = 01, no issueValid.
- JUMP 0x2001 at pc 7 → next memAddress = 9. CJUMP 0xC05D at pc 12 with condNonZero = 1 → pc = 10; with condNonZero = 0 → pc = 13.
- JUMP 0x20F0 at pc 3 (target −12) → FAULT, code 10, pc stays 3.
- Hold issueReady low 5 cycles → issueValid and issueInstr stay stable, pc frozen. `abort` in cycle 3 → IDLE, issueValid low in that cycle.
- MAX_STEPS = 4, program loops on 0x20FF → FAULT, code 11, stepCount = 4.
